// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported synchronous SRAM between instruction fetch and data access.
// Optional conflict counter is built when ARB_PERF_CNT_EN is defined.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_STARVE = 3,
    parameter int STARVE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [31:0]       conflict_cnt
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                resp_valid;
    logic                resp_owner;
    logic                force_inst;
    logic                gnt_inst;
    logic                gnt_data;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt);
        if (cnt >= STARVE_W'(MAX_STARVE))
            return STARVE_W'(MAX_STARVE);
        return cnt + STARVE_W'(1);
    endfunction

    // Grants are gated by reset so requests present during reset are ignored.
    assign force_inst = (starve_cnt == STARVE_W'(MAX_STARVE));
    assign gnt_inst   = ~reset & inst_req & (~data_req | force_inst);
    assign gnt_data   = ~reset & data_req & ~gnt_inst;

    assign inst_addr_ok = gnt_inst;
    assign data_addr_ok = gnt_data;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0;
        sram_addr  = '0;
        sram_wdata = 32'b0;
        if (gnt_inst) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (gnt_data) begin
            sram_en    = 1'b1;
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            resp_valid <= gnt_inst | gnt_data;
            resp_owner <= gnt_data;
            if (gnt_inst)
                starve_cnt <= '0;
            else if (inst_req & gnt_data)
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // The SRAM has a fixed one-cycle latency, so a single owner bit routes the response.
    assign inst_data_ok = ~reset & resp_valid & ~resp_owner;
    assign data_data_ok = ~reset & resp_valid & resp_owner;
    assign inst_rdata   = reset ? 32'b0 : sram_rdata;
    assign data_rdata   = reset ? 32'b0 : sram_rdata;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk) begin
        if (reset)
            conflict_q <= 32'b0;
        else if (inst_req & data_req)
            conflict_q <= conflict_q + 32'd1;
    end

    assign conflict_cnt = reset ? 32'b0 : conflict_q;
`else
    assign conflict_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'b0;
    logic [31:0] conflict_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .MAX_STARVE(3), .STARVE_W(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Behavioural SRAM: unwritten words return fixed preload contents.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] preload(input logic [31:0] a);
        case (a)
            32'h1c000000: return 32'h02800421;
            32'h1c000004: return 32'h11111111;
            32'h1c000008: return 32'h33333333;
            32'h00000200: return 32'h22222222;
            default:      return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return preload(a);
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we != 4'b0) begin
                logic [31:0] w;
                w = rd_word(sram_addr);
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                mem[sram_addr] = w;
                sram_rdata <= 32'hxxxxxxxx;
            end else begin
                sram_rdata <= rd_word(sram_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_req = ir; inst_addr = ia; data_req = dr;
        data_we = dw; data_addr = da; data_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic        en;
        logic [3:0]  we;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // ireq iaddr dreq dwe daddr dwdata | iaok daok idok ddok en we saddr swdata chk rdata
        vecs[0] = '{1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h1c000000, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h02800421};
        vecs[2] = '{1'b1, 32'h1c000000, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h1c000000, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h1c000004, 1'b0, 4'h0, 32'h0,   32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000004, 32'h0, 1'b1, 32'h02800421};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h200, 32'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 32'h11111111};
        vecs[6] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h22222222};
        vecs[7] = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h100, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,   32'h0,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF};

        // Reset with both requests pending: everything must stay quiet.
        reset = 1'b1;
        drive(1'b1, 32'h1c000000, 1'b1, 4'hF, 32'h100, 32'h1234);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_iaok", {31'b0, inst_addr_ok}, 32'd0);
            chk("rst_daok", {31'b0, data_addr_ok}, 32'd0);
            chk("rst_dok",  {30'b0, inst_data_ok, data_data_ok}, 32'd0);
            chk("rst_sram", {27'b0, sram_en, sram_we}, 32'd0);
            chk("rst_saddr", sram_addr | sram_wdata, 32'd0);
            chk("rst_conf", conflict_cnt, 32'd0);
            next_cycle();
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        next_cycle();

        // Table-driven single-cycle vectors, one per clock.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
            @(negedge clk);
            chk($sformatf("v%0d_iaok", i), {31'b0, inst_addr_ok}, {31'b0, vecs[i].iaok});
            chk($sformatf("v%0d_daok", i), {31'b0, data_addr_ok}, {31'b0, vecs[i].daok});
            chk($sformatf("v%0d_idok", i), {31'b0, inst_data_ok}, {31'b0, vecs[i].idok});
            chk($sformatf("v%0d_ddok", i), {31'b0, data_data_ok}, {31'b0, vecs[i].ddok});
            chk($sformatf("v%0d_en", i), {27'b0, sram_en, sram_we}, {27'b0, vecs[i].en, vecs[i].we});
            chk($sformatf("v%0d_saddr", i), sram_addr, vecs[i].saddr);
            chk($sformatf("v%0d_swdata", i), sram_wdata, vecs[i].swdata);
            if (vecs[i].chk_rd && vecs[i].idok)
                chk($sformatf("v%0d_irdata", i), inst_rdata, vecs[i].rdata);
            if (vecs[i].chk_rd && vecs[i].ddok)
                chk($sformatf("v%0d_drdata", i), data_rdata, vecs[i].rdata);
            next_cycle();
        end

        // Starvation guard: both held, expect D D D I D D D I.
        begin
            logic prev_i, prev_d;
            prev_i = 1'b0;
            prev_d = 1'b0;
            drive(1'b1, 32'h1c000008, 1'b1, 4'h0, 32'h200, 32'h0);
            for (int k = 0; k < 8; k++) begin
                logic exp_i;
                exp_i = (k == 3) || (k == 7);
                @(negedge clk);
                chk($sformatf("st%0d_iaok", k), {31'b0, inst_addr_ok}, {31'b0, exp_i});
                chk($sformatf("st%0d_daok", k), {31'b0, data_addr_ok}, {31'b0, ~exp_i});
                chk($sformatf("st%0d_idok", k), {31'b0, inst_data_ok}, {31'b0, prev_i});
                chk($sformatf("st%0d_ddok", k), {31'b0, data_data_ok}, {31'b0, prev_d});
                if (prev_i) chk($sformatf("st%0d_ird", k), inst_rdata, 32'h33333333);
                if (prev_d) chk($sformatf("st%0d_drd", k), data_rdata, 32'h22222222);
                prev_i = exp_i;
                prev_d = ~exp_i;
                next_cycle();
            end
            drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk("st_tail_idok", {31'b0, inst_data_ok}, 32'd1);
            chk("st_tail_ddok", {31'b0, data_data_ok}, 32'd0);
            chk("st_tail_ird", inst_rdata, 32'h33333333);
            next_cycle();
        end

        // Reset while a data read response is in flight.
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        chk("rmf_daok_N", {31'b0, data_addr_ok}, 32'd1);
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 32'h1c000000, 1'b1, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        chk("rmf_ddok_N1", {31'b0, data_data_ok}, 32'd0);
        chk("rmf_aok_N1", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rmf_en_N1", {31'b0, sram_en}, 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rmf_ddok_N2", {31'b0, data_data_ok}, 32'd0);
        chk("rmf_idok_N2", {31'b0, inst_data_ok}, 32'd0);
        chk("conf_start", conflict_cnt, 32'd0);
        next_cycle();

        // Conflict counter: 10 conflict cycles then 5 single-request cycles.
        for (int c = 0; c < 15; c++) begin
            if (c < 10)
                drive(1'b1, 32'h1c000000, 1'b1, 4'h0, 32'h200, 32'h0);
            else
                drive(1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0, 32'h0);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
`ifdef ARB_PERF_CNT_EN
        chk("conf_cnt", conflict_cnt, 32'd10);
`else
        chk("conf_cnt", conflict_cnt, 32'd0);
`endif
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
